// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports (0 = CPU, 1 = DMA), their
// response channels and the data-memory side of the arbiter.
//   reqN_*  : request from port N (valid, wren, addr, wdata, lock) and ready back
//   rspN_*  : one-cycle response strobe with read data and address-error flag
//   mem_*   : write enable / address / write data to memory, combinational read data
//   owner   : current ownership state (00 none, 01 port 0, 10 port 1)
// Modport slave is the arbiter side; master is the requester/memory side.
interface dmem_arbiter_if;
  logic        req0_valid;
  logic        req0_wren;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_lock;
  logic        req0_ready;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        rsp0_err;

  logic        req1_valid;
  logic        req1_wren;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_lock;
  logic        req1_ready;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        rsp1_err;

  logic        mem_wren;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic [1:0]  owner;

  modport slave (
    input  req0_valid, req0_wren, req0_addr, req0_wdata, req0_lock,
    input  req1_valid, req1_wren, req1_addr, req1_wdata, req1_lock,
    input  mem_data_out,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_wren, mem_address, mem_data_in, owner
  );

  modport master (
    output req0_valid, req0_wren, req0_addr, req0_wdata, req0_lock,
    output req1_valid, req1_wren, req1_addr, req1_wdata, req1_lock,
    output mem_data_out,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_wren, mem_address, mem_data_in, owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU / DMA) arbiter in front of a single-ported data
// memory with combinational read. Round-robin arbitration in IDLE, optional
// locked ownership bounded to MAX_LOCK consecutive grants, address checking,
// and a registered one-cycle-latency response per accepted transfer.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : dmem_arbiter_if.slave carrying request/response/memory signals
module dmem_arbiter #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter int unsigned MAX_LOCK = 8
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned LockW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  // Encoding doubles as the owner output.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic             last_served_q, last_served_d;

  logic             rsp0_valid_q, rsp0_valid_d;
  logic [31:0]      rsp0_rdata_q, rsp0_rdata_d;
  logic             rsp0_err_q, rsp0_err_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [31:0]      rsp1_rdata_q, rsp1_rdata_d;
  logic             rsp1_err_q, rsp1_err_d;

  logic             ready0, ready1, accept;
  logic             err0, err1;
  logic             sel_wren, sel_lock, sel_err;
  logic [31:0]      sel_addr, sel_wdata;

  function automatic logic addr_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0) ||
           ({22'd0, addr[11:2]} >= MEM_SIZE);
  endfunction

  assign err0 = addr_err(bus.req0_addr);
  assign err1 = addr_err(bus.req1_addr);

  // Grant logic; on a tie in IDLE the port not served last wins.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          ready0 = bus.req0_valid && (!bus.req1_valid || last_served_q);
          ready1 = bus.req1_valid && (!bus.req0_valid || !last_served_q);
        end
        StOwn0:  ready0 = bus.req0_valid;
        StOwn1:  ready1 = bus.req1_valid;
        default: ;
      endcase
    end
  end

  assign accept = ready0 | ready1;

  // Memory-side mux; everything reads zero when nobody is granted.
  always_comb begin
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    sel_wren  = 1'b0;
    sel_lock  = 1'b0;
    sel_err   = 1'b0;
    if (ready1) begin
      sel_addr  = bus.req1_addr;
      sel_wdata = bus.req1_wdata;
      sel_wren  = bus.req1_wren;
      sel_lock  = bus.req1_lock;
      sel_err   = err1;
    end else if (ready0) begin
      sel_addr  = bus.req0_addr;
      sel_wdata = bus.req0_wdata;
      sel_wren  = bus.req0_wren;
      sel_lock  = bus.req0_lock;
      sel_err   = err0;
    end
  end

  // Ownership / lock counter / round-robin pointer. Errored transfers count too.
  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = lock_cnt_q;
    last_served_d = last_served_q;
    if (accept) begin
      last_served_d = ready1;
      if (sel_lock && (lock_cnt_q != LockW'(MAX_LOCK - 1))) begin
        state_d    = ready1 ? StOwn1 : StOwn0;
        lock_cnt_d = lock_cnt_q + 1'b1;
      end else begin
        // Unlocked transfer, or lock budget exhausted: hand back to arbitration.
        state_d    = StIdle;
        lock_cnt_d = '0;
      end
    end
  end

  // Response capture: read data sampled from memory at the accept edge.
  always_comb begin
    rsp0_valid_d = ready0;
    rsp0_err_d   = ready0 && err0;
    rsp0_rdata_d = (ready0 && !bus.req0_wren && !err0) ? bus.mem_data_out : 32'd0;
    rsp1_valid_d = ready1;
    rsp1_err_d   = ready1 && err1;
    rsp1_rdata_d = (ready1 && !bus.req1_wren && !err1) ? bus.mem_data_out : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      lock_cnt_q    <= '0;
      last_served_q <= 1'b1;
      rsp0_valid_q  <= 1'b0;
      rsp0_rdata_q  <= 32'd0;
      rsp0_err_q    <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_rdata_q  <= 32'd0;
      rsp1_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      last_served_q <= last_served_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_rdata_q  <= rsp0_rdata_d;
      rsp0_err_q    <= rsp0_err_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_rdata_q  <= rsp1_rdata_d;
      rsp1_err_q    <= rsp1_err_d;
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.mem_wren    = accept && sel_wren && !sel_err;
  assign bus.mem_address = sel_addr;
  assign bus.mem_data_in = sel_wdata;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp0_rdata  = rsp0_rdata_q;
  assign bus.rsp0_err    = rsp0_err_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp1_rdata  = rsp1_rdata_q;
  assign bus.rsp1_err    = rsp1_err_q;
  assign bus.owner       = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// behavioural 1024-word memory whose unwritten words read 0xC0DE0000 | index.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .MEM_SIZE(1024),
    .MAX_LOCK(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (bus.mem_wren) begin
      mem[bus.mem_address[11:2]] <= bus.mem_data_in;
    end
  end
  assign bus.mem_data_out = mem[bus.mem_address[11:2]];

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic l);
    bus.req0_valid = v;
    bus.req0_wren  = w;
    bus.req0_addr  = a;
    bus.req0_wdata = d;
    bus.req0_lock  = l;
  endtask

  task automatic set1(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic l);
    bus.req1_valid = v;
    bus.req1_wren  = w;
    bus.req1_addr  = a;
    bus.req1_wdata = d;
    bus.req1_lock  = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic p1;
    reset = 1'b1;
    set0(1'b1, 1'b1, 32'h20, 32'h1111_1111, 1'b0);
    set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_w("rst_owner", 32'(bus.owner), 32'd0);
    chk_b("rst_rsp0v", bus.rsp0_valid, 1'b0);
    chk_b("rst_rsp1v", bus.rsp1_valid, 1'b0);
    chk_w("rst_rsp0d", bus.rsp0_rdata, 32'd0);
    chk_b("rst_rsp0e", bus.rsp0_err, 1'b0);
    chk_b("rst_ready0", bus.req0_ready, 1'b0);
    chk_b("rst_wren", bus.mem_wren, 1'b0);

    // Both ports read: grants alternate 0,1,0,1 starting with port 0.
    reset = 1'b0;
    set0(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    set1(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      p1 = (i % 2) == 1;
      #1;
      chk_b("rr_ready0", bus.req0_ready, !p1);
      chk_b("rr_ready1", bus.req1_ready, p1);
      chk_w("rr_addr", bus.mem_address, p1 ? 32'h40 : 32'h20);
      step();
      chk_b("rr_rsp0v", bus.rsp0_valid, !p1);
      chk_b("rr_rsp1v", bus.rsp1_valid, p1);
      if (p1) chk_w("rr_rsp1d", bus.rsp1_rdata, 32'hC0DE_0010);
      else    chk_w("rr_rsp0d", bus.rsp0_rdata, 32'hC0DE_0008);
    end

    // Port 0 write then back-to-back read of the same word.
    set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    #1;
    chk_b("wr_ready0", bus.req0_ready, 1'b1);
    chk_b("wr_wren", bus.mem_wren, 1'b1);
    chk_w("wr_addr", bus.mem_address, 32'h10);
    chk_w("wr_data", bus.mem_data_in, 32'hDEAD_BEEF);
    step();
    chk_b("wr_rspv", bus.rsp0_valid, 1'b1);
    chk_w("wr_rspd", bus.rsp0_rdata, 32'd0);
    chk_b("wr_rspe", bus.rsp0_err, 1'b0);
    set0(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    #1;
    chk_b("rd_wren", bus.mem_wren, 1'b0);
    chk_b("rd_ready0", bus.req0_ready, 1'b1);
    step();
    chk_b("rd_rspv", bus.rsp0_valid, 1'b1);
    chk_w("rd_rspd", bus.rsp0_rdata, 32'hDEAD_BEEF);
    chk_b("rd_rspe", bus.rsp0_err, 1'b0);
    set0(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    #1;
    chk_b("nil_ready0", bus.req0_ready, 1'b0);
    chk_w("nil_addr", bus.mem_address, 32'd0);
    step();
    chk_b("nil_rspv", bus.rsp0_valid, 1'b0);
    chk_b("nil_rspe", bus.rsp0_err, 1'b0);

    // Port 1 locked against a waiting port 0: eight grants, then port 0.
    set0(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    set1(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_b("lk_ready1", bus.req1_ready, 1'b1);
      chk_b("lk_ready0", bus.req0_ready, 1'b0);
      chk_w("lk_owner_pre", 32'(bus.owner), (i == 0) ? 32'd0 : 32'd2);
      step();
      chk_b("lk_rsp1v", bus.rsp1_valid, 1'b1);
      chk_w("lk_owner", 32'(bus.owner), (i < 7) ? 32'd2 : 32'd0);
    end
    #1;
    chk_b("lk_end_ready0", bus.req0_ready, 1'b1);
    chk_b("lk_end_ready1", bus.req1_ready, 1'b0);
    step();
    chk_b("lk_end_rsp0v", bus.rsp0_valid, 1'b1);
    chk_b("lk_end_rsp1v", bus.rsp1_valid, 1'b0);

    // Port 0 lock followed by an unlocked transfer releases ownership.
    set1(1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
    set0(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    #1;
    chk_b("l0_ready0", bus.req0_ready, 1'b1);
    step();
    chk_w("l0_owner", 32'(bus.owner), 32'd1);
    set0(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    set1(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    #1;
    chk_b("l0_ready1", bus.req1_ready, 1'b0);
    chk_b("l0_ready0b", bus.req0_ready, 1'b1);
    step();
    chk_w("l0_owner_rel", 32'(bus.owner), 32'd0);

    // Address errors, then the last valid word.
    set1(1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
    set0(1'b1, 1'b0, 32'h1002, 32'h0, 1'b0);
    #1;
    chk_b("e1_ready0", bus.req0_ready, 1'b1);
    chk_b("e1_wren", bus.mem_wren, 1'b0);
    step();
    chk_b("e1_rspv", bus.rsp0_valid, 1'b1);
    chk_b("e1_rspe", bus.rsp0_err, 1'b1);
    chk_w("e1_rspd", bus.rsp0_rdata, 32'd0);
    set0(1'b1, 1'b1, 32'h1000, 32'h1234_5678, 1'b0);
    #1;
    chk_b("e2_wren", bus.mem_wren, 1'b0);
    step();
    chk_b("e2_rspv", bus.rsp0_valid, 1'b1);
    chk_b("e2_rspe", bus.rsp0_err, 1'b1);
    set0(1'b1, 1'b1, 32'hFFC, 32'hCAFE_F00D, 1'b0);
    #1;
    chk_b("top_wren", bus.mem_wren, 1'b1);
    chk_w("top_addr", bus.mem_address, 32'hFFC);
    step();
    chk_b("top_rspe", bus.rsp0_err, 1'b0);
    set0(1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0);
    step();
    chk_w("top_rspd", bus.rsp0_rdata, 32'hCAFE_F00D);
    chk_b("top_rdrspe", bus.rsp0_err, 1'b0);

    // Port 1 takes a lock, goes idle: port 0 stays stalled.
    set0(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    set1(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    #1;
    chk_b("st_ready1", bus.req1_ready, 1'b1);
    step();
    chk_w("st_owner", 32'(bus.owner), 32'd2);
    set1(1'b0, 1'b0, 32'h40, 32'h0, 1'b1);
    set0(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    repeat (2) begin
      #1;
      chk_b("st_ready0", bus.req0_ready, 1'b0);
      chk_w("st_addr", bus.mem_address, 32'd0);
      step();
      chk_w("st_owner_hold", 32'(bus.owner), 32'd2);
      chk_b("st_rsp0v", bus.rsp0_valid, 1'b0);
    end
    set1(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    #1;
    chk_b("st_ready1b", bus.req1_ready, 1'b1);
    chk_b("st_ready0b", bus.req0_ready, 1'b0);
    step();
    chk_b("st_rsp1v", bus.rsp1_valid, 1'b1);

    // Reset while port 1 owns with a response pending.
    reset = 1'b1;
    #1;
    chk_b("mr_ready1", bus.req1_ready, 1'b0);
    chk_b("mr_ready0", bus.req0_ready, 1'b0);
    step();
    chk_w("mr_owner", 32'(bus.owner), 32'd0);
    chk_b("mr_rsp1v", bus.rsp1_valid, 1'b0);
    chk_w("mr_rsp1d", bus.rsp1_rdata, 32'd0);
    reset = 1'b0;
    #1;
    chk_b("pr_ready0", bus.req0_ready, 1'b1);
    chk_b("pr_ready1", bus.req1_ready, 1'b0);
    step();
    chk_b("pr_rsp0v", bus.rsp0_valid, 1'b1);
    chk_w("pr_rsp0d", bus.rsp0_rdata, 32'hC0DE_0008);
    chk_w("pr_owner", 32'(bus.owner), 32'd0);

    set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
